// File: rtl/seq_gen.sv
// seq_gen: ADC phase sequencer producing INIT/SAMP/COMP/LOGIC strobes.
// Optional SEQ_GEN_NONOVERLAP_EN inserts an all-low gap cycle after each phase.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, cont         conversion request (level), continuous re-arm
//   cfg_t_init/samp/comp/logic  phase length minus 1 (TW bits each)
//   cfg_ncomp           number of COMP/LOGIC pairs minus 1 (NW bits)
//   seq_init/samp/comp/logic    phase strobes, one-hot or all low
//   busy, conv_done     conversion active, one-cycle completion pulse
//   comp_idx            0-based index of the current comparison
module seq_gen #(
    parameter int TW = 4,
    parameter int NW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cont,
    input  logic [TW-1:0] cfg_t_init,
    input  logic [TW-1:0] cfg_t_samp,
    input  logic [TW-1:0] cfg_t_comp,
    input  logic [TW-1:0] cfg_t_logic,
    input  logic [NW-1:0] cfg_ncomp,
    output logic          seq_init,
    output logic          seq_samp,
    output logic          seq_comp,
    output logic          seq_logic,
    output logic          busy,
    output logic          conv_done,
    output logic [NW-1:0] comp_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SAMP,
        S_COMP,
        S_LOGIC,
        S_DONE,
        S_GAP
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_cnt;
    logic [NW-1:0] r_idx;
    // INIT length is consumed on the same edge it is latched, so it
    // needs no shadow; the other lengths are used later in the run.
    logic [TW-1:0] r_ts;
    logic [TW-1:0] r_tc;
    logic [TW-1:0] r_tl;
    logic [NW-1:0] r_nc;
    logic          r_init;
    logic          r_samp;
    logic          r_comp;
    logic          r_logic;
    logic          r_busy;
    logic          r_done;

    state_t        w_nxt;
    state_t        w_tgt;
    logic [TW-1:0] w_cnt;
    logic [NW-1:0] w_idx;
    logic          w_latch;
    logic          w_end;

`ifdef SEQ_GEN_NONOVERLAP_EN
    // Phase to enter once the gap cycle is over.
    state_t        r_after;
    state_t        w_after;
`endif

    function automatic logic [TW-1:0] f_len(
        input state_t        t,
        input logic [TW-1:0] ts,
        input logic [TW-1:0] tc,
        input logic [TW-1:0] tl
    );
        logic [TW-1:0] v;
        v = '0;
        case (t)
            S_SAMP:  v = ts;
            S_COMP:  v = tc;
            S_LOGIC: v = tl;
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        w_nxt   = r_state;
        w_tgt   = S_IDLE;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_latch = 1'b0;
        w_end   = 1'b0;
`ifdef SEQ_GEN_NONOVERLAP_EN
        w_after = r_after;
`endif
        case (r_state)
            S_IDLE: begin
                w_idx = '0;
                if (start) begin
                    w_latch = 1'b1;
                    w_nxt   = S_INIT;
                    w_cnt   = cfg_t_init;
                end
            end
            S_INIT: begin
                w_end = (r_cnt == '0);
                w_cnt = r_cnt - 1'b1;
                w_tgt = S_SAMP;
            end
            S_SAMP: begin
                w_end = (r_cnt == '0);
                w_cnt = r_cnt - 1'b1;
                w_tgt = S_COMP;
            end
            S_COMP: begin
                w_end = (r_cnt == '0);
                w_cnt = r_cnt - 1'b1;
                w_tgt = S_LOGIC;
            end
            S_LOGIC: begin
                w_end = (r_cnt == '0);
                w_cnt = r_cnt - 1'b1;
                if (r_idx < r_nc) begin
                    w_tgt = S_COMP;
                    if (w_end) w_idx = r_idx + 1'b1;
                end else begin
                    w_tgt = S_DONE;
                end
            end
            S_DONE: begin
                w_idx = '0;
                if (cont || start) begin
                    w_latch = 1'b1;
                    w_nxt   = S_INIT;
                    w_cnt   = cfg_t_init;
                end else begin
                    w_nxt = S_IDLE;
                end
            end
`ifdef SEQ_GEN_NONOVERLAP_EN
            S_GAP: begin
                w_nxt = r_after;
                w_cnt = f_len(r_after, r_ts, r_tc, r_tl);
            end
`endif
            default: w_nxt = S_IDLE;
        endcase

        if (w_end) begin
`ifdef SEQ_GEN_NONOVERLAP_EN
            w_nxt   = S_GAP;
            w_after = w_tgt;
`else
            w_nxt = w_tgt;
            w_cnt = f_len(w_tgt, r_ts, r_tc, r_tl);
`endif
        end
    end

    // Outputs are decoded from the next state so each one is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ts    <= '0;
            r_tc    <= '0;
            r_tl    <= '0;
            r_nc    <= '0;
            r_init  <= 1'b0;
            r_samp  <= 1'b0;
            r_comp  <= 1'b0;
            r_logic <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SEQ_GEN_NONOVERLAP_EN
            r_after <= S_IDLE;
`endif
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            if (w_latch) begin
                r_ts <= cfg_t_samp;
                r_tc <= cfg_t_comp;
                r_tl <= cfg_t_logic;
                r_nc <= cfg_ncomp;
            end
            r_init  <= (w_nxt == S_INIT);
            r_samp  <= (w_nxt == S_SAMP);
            r_comp  <= (w_nxt == S_COMP);
            r_logic <= (w_nxt == S_LOGIC);
            r_busy  <= (w_nxt != S_IDLE);
            r_done  <= (w_nxt == S_DONE);
`ifdef SEQ_GEN_NONOVERLAP_EN
            r_after <= w_after;
`endif
        end
    end

    assign seq_init  = r_init;
    assign seq_samp  = r_samp;
    assign seq_comp  = r_comp;
    assign seq_logic = r_logic;
    assign busy      = r_busy;
    assign conv_done = r_done;
    assign comp_idx  = r_idx;

endmodule
